rs_encode_line_mux_out: RTL and testbench

// - Output stage of the line-interface RS encoder; sits directly after rs_encode_line_mux_in.
// - Consumes the RS_N codeword bytes (K data + parity) one byte at a time from the encoder output FIFO.
// - Packs the bytes into DATA_W-wide lines and emits them with val/rdy.
// - Runs the done handshake with the input controller, so the next message is admitted only after this codeword has left.

---
 rtl/rs_encode_pkg.sv | 14 +
 rtl/rs_encode_line_out_datap.sv | 69 ++++++
 rtl/rs_encode_line_mux_out.sv | 108 ++++++++++
 tb/tb_rs_encode_line_mux_out.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_encode_pkg.sv
// Shared constants and types for the line-interface RS encoder.
package rs_encode_pkg;

  localparam int unsigned RS_N      = 255;
  localparam int unsigned RS_K      = 223;
  localparam int unsigned RS_WORD_W = 8;

  typedef enum logic [1:0] {
    ACCUM     = 2'd0,
    OUT_LINE  = 2'd1,
    DONE_WAIT = 2'd2
  } rs_line_out_state_e;

endpackage

// File: rtl/rs_encode_line_out_datap.sv
// Output-side datapath: big-endian line packing register, byte offset and line counter.
module rs_encode_line_out_datap
  import rs_encode_pkg::*;
#(
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned DATA_BYTES      = DATA_W / 8,
  parameter int unsigned DATA_BYTES_W    = $clog2(DATA_BYTES),
  parameter int unsigned NUM_LINES       = (RS_N + DATA_BYTES - 1) / DATA_BYTES,
  parameter int unsigned LAST_LINE_BYTES = DATA_BYTES,
  parameter int unsigned LINE_CNT_W      = $clog2(NUM_LINES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_state_i,
  input  logic                 store_byte_i,
  input  logic                 incr_line_i,
  input  logic [RS_WORD_W-1:0] byte_i,
  output logic                 line_full_o,
  output logic                 last_line_o,
  output logic [DATA_W-1:0]    line_o
);

  logic [DATA_W-1:0]       line_q, line_d;
  logic [DATA_BYTES_W-1:0] off_q, off_d;
  logic [LINE_CNT_W-1:0]   cnt_q, cnt_d;

  assign last_line_o = (cnt_q == LINE_CNT_W'(NUM_LINES - 1));
  assign line_full_o = (off_q == DATA_BYTES_W'(DATA_BYTES - 1)) ||
                       (last_line_o && (off_q == DATA_BYTES_W'(LAST_LINE_BYTES - 1)));
  assign line_o      = line_q;

  // Clearing on every line boundary leaves the unused tail of the last line zero.
  always_comb begin
    line_d = line_q;
    off_d  = off_q;
    cnt_d  = cnt_q;
    if (init_state_i) begin
      line_d = '0;
      off_d  = '0;
      cnt_d  = '0;
    end else if (incr_line_i) begin
      line_d = '0;
      off_d  = '0;
      cnt_d  = cnt_q + LINE_CNT_W'(1);
    end else if (store_byte_i) begin
      for (int unsigned b = 0; b < DATA_BYTES; b++) begin
        if (off_q == DATA_BYTES_W'(b)) begin
          line_d[DATA_W-1-RS_WORD_W*b -: RS_WORD_W] = byte_i;
        end
      end
      if (!line_full_o) begin
        off_d = off_q + DATA_BYTES_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      off_q  <= off_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rs_encode_line_mux_out.sv
// RS encoder output stage: packs codeword bytes into DATA_W lines and closes the
// done handshake with the input controller once the whole codeword has left.
module rs_encode_line_mux_out
  import rs_encode_pkg::*;
#(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned DATA_BYTES   = DATA_W / 8,
  parameter int unsigned DATA_BYTES_W = $clog2(DATA_BYTES),
  parameter int unsigned NUM_LINES    = (RS_N + DATA_BYTES - 1) / DATA_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 encoder_dst_byte_val,
  input  logic [RS_WORD_W-1:0] encoder_dst_byte,
  output logic                 dst_encoder_byte_rdy,
  output logic                 encoder_dst_line_val,
  output logic [DATA_W-1:0]    encoder_dst_line,
  output logic                 encoder_dst_line_last,
  input  logic                 dst_encoder_line_rdy,
  input  logic                 in_ctrl_out_done,
  output logic                 out_in_ctrl_done
);

  localparam int unsigned LAST_LINE_BYTES = ((RS_N % DATA_BYTES) == 0) ? DATA_BYTES
                                                                       : (RS_N % DATA_BYTES);
  localparam int unsigned LINE_CNT_W      = $clog2(NUM_LINES + 1);

  rs_line_out_state_e state_q;
  logic byte_rdy_q, line_val_q, line_last_q, done_q;
  logic init_state_c, store_byte_c, incr_line_c;
  logic line_full, last_line;

  assign store_byte_c = (state_q == ACCUM) && encoder_dst_byte_val;
  assign incr_line_c  = (state_q == OUT_LINE) && dst_encoder_line_rdy && !line_last_q;
  assign init_state_c = (state_q == DONE_WAIT) && done_q;

  rs_encode_line_out_datap #(
    .DATA_W          (DATA_W),
    .DATA_BYTES      (DATA_BYTES),
    .DATA_BYTES_W    (DATA_BYTES_W),
    .NUM_LINES       (NUM_LINES),
    .LAST_LINE_BYTES (LAST_LINE_BYTES),
    .LINE_CNT_W      (LINE_CNT_W)
  ) u_datap (
    .clk          (clk),
    .rst          (rst),
    .init_state_i (init_state_c),
    .store_byte_i (store_byte_c),
    .incr_line_i  (incr_line_c),
    .byte_i       (encoder_dst_byte),
    .line_full_o  (line_full),
    .last_line_o  (last_line),
    .line_o       (encoder_dst_line)
  );

  // DONE_WAIT spends one cycle detecting the input done and one cycle pulsing it back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      byte_rdy_q  <= 1'b1;
      line_val_q  <= 1'b0;
      line_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ACCUM: begin
          if (store_byte_c && line_full) begin
            state_q     <= OUT_LINE;
            byte_rdy_q  <= 1'b0;
            line_val_q  <= 1'b1;
            line_last_q <= last_line;
          end
        end
        OUT_LINE: begin
          if (dst_encoder_line_rdy) begin
            line_val_q  <= 1'b0;
            line_last_q <= 1'b0;
            if (line_last_q) begin
              state_q <= DONE_WAIT;
            end else begin
              state_q    <= ACCUM;
              byte_rdy_q <= 1'b1;
            end
          end
        end
        DONE_WAIT: begin
          if (done_q) begin
            state_q    <= ACCUM;
            byte_rdy_q <= 1'b1;
          end else if (in_ctrl_out_done) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ACCUM;
          byte_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign dst_encoder_byte_rdy  = byte_rdy_q;
  assign encoder_dst_line_val  = line_val_q;
  assign encoder_dst_line_last = line_last_q;
  assign out_in_ctrl_done      = done_q;

endmodule

// File: tb/tb_rs_encode_line_mux_out.sv
// Bench for rs_encode_line_mux_out: randomized byte source / line sink against a
// byte-index packing model, plus a narrow 64-bit instance for the padding case.
`timescale 1ns/1ps
module tb_rs_encode_line_mux_out;
  import rs_encode_pkg::*;

  localparam int DW  = 512;
  localparam int DB  = DW / 8;
  localparam int NL  = (int'(RS_N) + DB - 1) / DB;
  localparam int NDW = 64;
  localparam int NDB = NDW / 8;
  localparam int NNL = (int'(RS_N) + NDB - 1) / NDB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          byte_val = 1'b0;
  logic [7:0]    byte_d   = 8'h00;
  logic          byte_rdy;
  logic          line_val;
  logic [DW-1:0] line_d;
  logic          line_last;
  logic          line_rdy = 1'b1;
  logic          in_done  = 1'b0;
  logic          out_done;

  logic           n_val     = 1'b0;
  logic [7:0]     n_byte    = 8'h00;
  logic           n_rdy;
  logic           n_lval;
  logic [NDW-1:0] n_line;
  logic           n_last;
  logic           n_lrdy    = 1'b1;
  logic           n_in_done = 1'b1;
  logic           n_done;

  rs_encode_line_mux_out u_dut (
    .clk                   (clk),
    .rst                   (rst),
    .encoder_dst_byte_val  (byte_val),
    .encoder_dst_byte      (byte_d),
    .dst_encoder_byte_rdy  (byte_rdy),
    .encoder_dst_line_val  (line_val),
    .encoder_dst_line      (line_d),
    .encoder_dst_line_last (line_last),
    .dst_encoder_line_rdy  (line_rdy),
    .in_ctrl_out_done      (in_done),
    .out_in_ctrl_done      (out_done)
  );

  rs_encode_line_mux_out #(.DATA_W(NDW)) u_dut64 (
    .clk                   (clk),
    .rst                   (rst),
    .encoder_dst_byte_val  (n_val),
    .encoder_dst_byte      (n_byte),
    .dst_encoder_byte_rdy  (n_rdy),
    .encoder_dst_line_val  (n_lval),
    .encoder_dst_line      (n_line),
    .encoder_dst_line_last (n_last),
    .dst_encoder_line_rdy  (n_lrdy),
    .in_ctrl_out_done      (n_in_done),
    .out_in_ctrl_done      (n_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Environment knobs and scoreboard state.
  bit            feed_pause = 1'b0;
  bit            rand_val   = 1'b0;
  bit            sink_en    = 1'b1;
  bit            sink_rand  = 1'b0;
  logic [7:0]    src_q[$];
  logic [DW-1:0] rx_line[$];
  bit            rx_last[$];
  int            n_acc   = 0;
  int            n_pulse = 0;
  logic [7:0]    cw [RS_N];

  // Expected line idx of a codeword: byte k = idx*db+o, big-endian, zero past RS_N.
  function automatic logic [DW-1:0] exp_line(input int db, input int idx, input logic [7:0] c [RS_N]);
    logic [DW-1:0] r;
    int k;
    r = '0;
    for (int o = 0; o < db; o++) begin
      k = idx * db + o;
      if (k < int'(RS_N)) r[(db-1-o)*8 +: 8] = c[k];
    end
    return r;
  endfunction

  // Byte source and line sink; values sampled at a negedge hold through the next posedge.
  initial begin : env
    bit rdy_s, lval_s, lrdy_s, last_s;
    logic [DW-1:0] line_s;
    logic [7:0] tmp;
    rdy_s = 0; lval_s = 0; lrdy_s = 0; last_s = 0; line_s = '0;
    forever begin
      @(negedge clk);
      if (byte_val && rdy_s) begin
        tmp = src_q.pop_front();
        n_acc++;
      end
      if (lval_s && lrdy_s) begin
        rx_line.push_back(line_s);
        rx_last.push_back(last_s);
      end
      if (out_done) n_pulse++;
      rdy_s  = byte_rdy;
      lval_s = line_val;
      line_s = line_d;
      last_s = line_last;
      line_rdy = sink_en && (!sink_rand || ($urandom_range(1, 0) == 1));
      lrdy_s   = line_rdy;
      if (!feed_pause && src_q.size() > 0 && (!rand_val || ($urandom_range(1, 0) == 1))) begin
        byte_val = 1'b1;
        byte_d   = src_q[0];
      end else begin
        byte_val = 1'b0;
        byte_d   = 8'($urandom);
      end
    end
  end

  task automatic load_cw(input bit rnd);
    for (int i = 0; i < int'(RS_N); i++) begin
      cw[i] = rnd ? 8'($urandom) : 8'(i);
      src_q.push_back(cw[i]);
    end
  endtask

  task automatic wait_lines(input int n);
    for (int c = 0; c < 3000 && rx_line.size() < n; c++) @(negedge clk);
  endtask

  task automatic handshake(output int pulses);
    int p0;
    p0 = n_pulse;
    in_done = 1'b1;
    repeat (8) @(negedge clk);
    in_done = 1'b0;
    repeat (2) @(negedge clk);
    pulses = n_pulse - p0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      n_cmp++; if (byte_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_byte_rdy ph%0d got %b want 1", ph, byte_rdy); end
      n_cmp++; if (line_val !== 1'b0) begin n_bad++; $display("FAIL reset_line_val ph%0d got %b want 0", ph, line_val); end
      n_cmp++; if (line_last !== 1'b0) begin n_bad++; $display("FAIL reset_line_last ph%0d got %b want 0", ph, line_last); end
      n_cmp++; if (out_done !== 1'b0) begin n_bad++; $display("FAIL reset_done ph%0d got %b want 0", ph, out_done); end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    int pulses;
    rx_line.delete(); rx_last.delete();
    rand_val = 0; sink_en = 1; sink_rand = 0;
    load_cw(1'b0);
    wait_lines(NL);
    n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL basic_count got %0d want %0d", rx_line.size(), NL); end
    for (int i = 0; i < NL && i < rx_line.size(); i++) begin
      n_cmp++; if (rx_line[i] !== exp_line(DB, i, cw)) begin n_bad++; $display("FAIL basic_line%0d got %h want %h", i, rx_line[i], exp_line(DB, i, cw)); end
      n_cmp++; if (rx_last[i] !== (i == NL - 1)) begin n_bad++; $display("FAIL basic_last%0d got %b want %b", i, rx_last[i], (i == NL - 1)); end
    end
    if (rx_line.size() == NL) begin
      n_cmp++; if (rx_line[0][511:504] !== 8'h00 || rx_line[0][7:0] !== 8'h3F) begin n_bad++; $display("FAIL basic_line0_ends got %h/%h want 00/3f", rx_line[0][511:504], rx_line[0][7:0]); end
      n_cmp++; if (rx_line[3][511:504] !== 8'hC0 || rx_line[3][15:8] !== 8'hFE || rx_line[3][7:0] !== 8'h00) begin n_bad++; $display("FAIL basic_line3_ends got %h/%h/%h want c0/fe/00", rx_line[3][511:504], rx_line[3][15:8], rx_line[3][7:0]); end
    end
    handshake(pulses);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_done_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] snap;
    logic snap_last;
    int acc0, pulses;
    rx_line.delete(); rx_last.delete();
    rand_val = 0; sink_en = 1; sink_rand = 0;
    load_cw(1'b1);
    wait_lines(1);
    sink_en = 0;
    for (int c = 0; c < 500 && line_val !== 1'b1; c++) @(negedge clk);
    @(negedge clk);
    snap = line_d; snap_last = line_last; acc0 = n_acc;
    n_cmp++; if (snap !== exp_line(DB, 1, cw)) begin n_bad++; $display("FAIL bp_line1 got %h want %h", snap, exp_line(DB, 1, cw)); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++; if (line_val !== 1'b1) begin n_bad++; $display("FAIL bp_val c%0d got %b want 1", c, line_val); end
      n_cmp++; if (line_d !== snap || line_last !== 1'b0) begin n_bad++; $display("FAIL bp_hold c%0d got %h/%b want %h/0", c, line_d, line_last, snap); end
      n_cmp++; if (byte_rdy !== 1'b0 || n_acc !== acc0) begin n_bad++; $display("FAIL bp_no_byte c%0d got rdy %b acc %0d want 0/%0d", c, byte_rdy, n_acc, acc0); end
    end
    sink_en = 1;
    wait_lines(NL);
    n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL bp_count got %0d want %0d", rx_line.size(), NL); end
    for (int i = 0; i < NL && i < rx_line.size(); i++) begin
      n_cmp++; if (rx_line[i] !== exp_line(DB, i, cw) || rx_last[i] !== (i == NL - 1)) begin n_bad++; $display("FAIL bp_line%0d got %h/%b want %h", i, rx_line[i], rx_last[i], exp_line(DB, i, cw)); end
    end
    handshake(pulses);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL bp_done_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_done_wait();
    int acc0, p0, pulses;
    bit seen;
    rx_line.delete(); rx_last.delete();
    rand_val = 0; sink_en = 1; sink_rand = 0;
    load_cw(1'b1);
    wait_lines(NL);
    n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL dw_count got %0d want %0d", rx_line.size(), NL); end
    rx_line.delete(); rx_last.delete();
    rand_val = 1;
    load_cw(1'b1);
    acc0 = n_acc; p0 = n_pulse;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_cmp++; if (byte_rdy !== 1'b0 || out_done !== 1'b0 || line_val !== 1'b0) begin n_bad++; $display("FAIL dw_hold c%0d got rdy %b done %b val %b want 0/0/0", c, byte_rdy, out_done, line_val); end
    end
    n_cmp++; if (n_acc !== acc0 || n_pulse !== p0) begin n_bad++; $display("FAIL dw_idle got acc %0d pulses %0d want %0d/%0d", n_acc, n_pulse, acc0, p0); end
    in_done = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (out_done === 1'b1);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL dw_pulse got none want 1"); end
    @(negedge clk);
    in_done = 1'b0;
    n_cmp++; if (byte_rdy !== 1'b1 || out_done !== 1'b0) begin n_bad++; $display("FAIL dw_after got rdy %b done %b want 1/0", byte_rdy, out_done); end
    wait_lines(NL);
    n_cmp++; if (n_pulse - p0 !== 1) begin n_bad++; $display("FAIL dw_pulse_count got %0d want 1", n_pulse - p0); end
    n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL dw_cw2_count got %0d want %0d", rx_line.size(), NL); end
    for (int i = 0; i < NL && i < rx_line.size(); i++) begin
      n_cmp++; if (rx_line[i] !== exp_line(DB, i, cw) || rx_last[i] !== (i == NL - 1)) begin n_bad++; $display("FAIL dw_cw2_line%0d got %h/%b want %h", i, rx_line[i], rx_last[i], exp_line(DB, i, cw)); end
    end
    handshake(pulses);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL dw_cw2_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_random();
    int pulses;
    rand_val = 1; sink_en = 1; sink_rand = 1;
    for (int k = 0; k < 2; k++) begin
      rx_line.delete(); rx_last.delete();
      load_cw(1'b1);
      wait_lines(NL);
      n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL rnd%0d_count got %0d want %0d", k, rx_line.size(), NL); end
      for (int i = 0; i < NL && i < rx_line.size(); i++) begin
        n_cmp++; if (rx_line[i] !== exp_line(DB, i, cw) || rx_last[i] !== (i == NL - 1)) begin n_bad++; $display("FAIL rnd%0d_line%0d got %h/%b want %h", k, i, rx_line[i], rx_last[i], exp_line(DB, i, cw)); end
      end
      if (rx_line.size() == NL) begin
        n_cmp++; if (rx_line[NL-1][7:0] !== 8'h00) begin n_bad++; $display("FAIL rnd%0d_pad got %h want 00", k, rx_line[NL-1][7:0]); end
      end
      handshake(pulses);
      n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL rnd%0d_pulses got %0d want 1", k, pulses); end
    end
    sink_rand = 0; rand_val = 0;
  endtask

  task automatic test_mid_reset();
    int pulses;
    rx_line.delete(); rx_last.delete();
    rand_val = 1; sink_en = 1; sink_rand = 0;
    n_acc = 0;
    load_cw(1'b1);
    for (int c = 0; c < 2000 && n_acc < 100; c++) @(negedge clk);
    feed_pause = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (line_val !== 1'b0 || byte_rdy !== 1'b1 || out_done !== 1'b0) begin n_bad++; $display("FAIL mr_outputs got val %b rdy %b done %b want 0/1/0", line_val, byte_rdy, out_done); end
    src_q.delete(); rx_line.delete(); rx_last.delete();
    repeat (3) @(negedge clk);
    n_cmp++; if (rx_line.size() !== 0 || line_val !== 1'b0) begin n_bad++; $display("FAIL mr_no_line got %0d/%b want 0/0", rx_line.size(), line_val); end
    rand_val = 0;
    load_cw(1'b1);
    feed_pause = 0;
    wait_lines(NL);
    n_cmp++; if (rx_line.size() !== NL) begin n_bad++; $display("FAIL mr_count got %0d want %0d", rx_line.size(), NL); end
    for (int i = 0; i < NL && i < rx_line.size(); i++) begin
      n_cmp++; if (rx_line[i] !== exp_line(DB, i, cw) || rx_last[i] !== (i == NL - 1)) begin n_bad++; $display("FAIL mr_line%0d got %h/%b want %h", i, rx_line[i], rx_last[i], exp_line(DB, i, cw)); end
    end
    handshake(pulses);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL mr_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_narrow();
    logic [7:0]     cwn [RS_N];
    logic [NDW-1:0] nl[$];
    bit             nlast[$];
    logic [DW-1:0]  e;
    int idx, dones;
    for (int i = 0; i < int'(RS_N); i++) cwn[i] = 8'($urandom);
    idx = 0; dones = 0;
    for (int c = 0; c < 3000 && nl.size() < NNL; c++) begin
      @(negedge clk);
      if (n_lval) begin nl.push_back(n_line); nlast.push_back(n_last); end
      if (n_done) dones++;
      n_val  = (idx < int'(RS_N));
      n_byte = (idx < int'(RS_N)) ? cwn[idx] : 8'h00;
      if (n_val && n_rdy) idx++;
    end
    n_val = 1'b0;
    repeat (6) begin @(negedge clk); if (n_done) dones++; end
    n_cmp++; if (nl.size() !== NNL) begin n_bad++; $display("FAIL nar_count got %0d want %0d", nl.size(), NNL); end
    for (int i = 0; i < NNL && i < nl.size(); i++) begin
      e = exp_line(NDB, i, cwn);
      n_cmp++; if (nl[i] !== e[NDW-1:0] || nlast[i] !== (i == NNL - 1)) begin n_bad++; $display("FAIL nar_line%0d got %h/%b want %h", i, nl[i], nlast[i], e[NDW-1:0]); end
    end
    if (nl.size() == NNL) begin
      n_cmp++; if (nl[NNL-1][7:0] !== 8'h00 || nl[NNL-1][15:8] !== cwn[254]) begin n_bad++; $display("FAIL nar_pad got %h want %h00", nl[NNL-1][15:0], cwn[254]); end
    end
    n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL nar_done got %0d want 1", dones); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_done_wait();
    test_random();
    test_mid_reset();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
